// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state type, AXI encodings and line/slot geometry helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_ADDR  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Bytes covered by one line fetch burst.
    function automatic int line_bytes(input int burst_len,
                                      input int data_width);
        return burst_len * data_width / 8;
    endfunction

    // 32-bit instruction slots delivered by one line fetch burst.
    function automatic int line_slots(input int burst_len,
                                      input int data_width);
        return burst_len * data_width / 32;
    endfunction

    // AXI arsize encoding for a full-width beat.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction queue with multi-lane push and flush.
// Ports: clk/reset, flush, push_en/push_data (LANES entries per cycle,
// lane 0 first), pop, head (oldest entry), empty, count (occupancy).
module inst_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 96,
    parameter int LANES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [LANES-1:0]         push_en,
    input  logic [LANES*WIDTH-1:0]   push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    n_push;
    logic [AW-1:0]    waddr [LANES];
    logic             do_pop;

    // Enabled lanes are packed densely behind the write pointer.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < LANES; i++) begin
            waddr[i] = wr_ptr + n_push[AW-1:0];
            n_push   = n_push + CW'(push_en[i]);
        end
    end

    assign empty  = (count == '0);
    assign do_pop = pop && !empty && !flush;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < LANES; i++) begin
                if (push_en[i]) begin
                    mem[waddr[i]] <= push_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + n_push - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: line-burst AXI reads into an instruction queue.
// Ports: clk/reset, entry (reset PC), redirect_valid/redirect_pc,
// AXI AR/R master channels, out_* decode stream, fetch_err sticky flag.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  fetch_err
);

    localparam int LINE_B  = line_bytes(BURST_LEN, DATA_WIDTH);
    localparam int NSLOT   = line_slots(BURST_LEN, DATA_WIDTH);
    localparam int LANES   = DATA_WIDTH / 32;
    localparam int BEAT_SH = $clog2(DATA_WIDTH / 8);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int EW      = ADDR_WIDTH + 32;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~ADDR_WIDTH'(LINE_B - 1);

    fetch_state_e          state, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] pend_pc, pend_pc_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  redir_q, redir_d;
    logic                  halt_q, halt_d;
    logic                  err_q, err_d;
    logic [7:0]            beat_q, beat_d;

    logic [LANES-1:0]      push_en;
    logic [LANES*EW-1:0]   push_data;
    logic [ADDR_WIDTH-1:0] lane_pc [LANES];
    logic [ADDR_WIDTH-1:0] beat_base;
    logic [EW-1:0]         head;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  credit_ok;
    logic                  beat_ok;

    // A line is only requested when the whole burst is sure to fit.
    assign credit_ok = (CW'(FIFO_DEPTH) - fifo_count) >= CW'(NSLOT);

    assign beat_base = araddr_q + (ADDR_WIDTH'(beat_q) << BEAT_SH);
    assign beat_ok   = (state == ST_DATA) && m_axi_rvalid &&
                       (m_axi_rresp == AXI_RESP_OKAY) &&
                       !redirect_valid;

    // Slots before the fetch PC belong to an unaligned entry point.
    always_comb begin
        push_en   = '0;
        push_data = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_pc[j] = beat_base + ADDR_WIDTH'(4 * j);
            push_data[j*EW +: EW] =
                {lane_pc[j], m_axi_rdata[j*32 +: 32]};
            push_en[j] = beat_ok && (lane_pc[j] >= fetch_pc);
        end
    end

    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        pend_pc_d  = pend_pc;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        redir_d    = redir_q;
        halt_d     = halt_q;
        err_d      = err_q;
        beat_d     = beat_q;
        if (redirect_valid) begin
            err_d = 1'b0;
        end
        unique case (state)
            ST_ADDR: begin
                if (arvalid_q) begin
                    // An offered AR must complete; the redirect waits.
                    if (redirect_valid) begin
                        redir_d   = 1'b1;
                        pend_pc_d = redirect_pc;
                    end
                    if (m_axi_arready) begin
                        arvalid_d = 1'b0;
                        beat_d    = '0;
                        if (redirect_valid || redir_q) begin
                            state_d = ST_DRAIN;
                            halt_d  = 1'b0;
                            redir_d = 1'b0;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end else if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else if (credit_ok) begin
                    arvalid_d = 1'b1;
                    araddr_d  = fetch_pc & LINE_MASK;
                end
            end
            ST_DATA: begin
                if (m_axi_rvalid) begin
                    beat_d = beat_q + 8'd1;
                end
                if (redirect_valid) begin
                    if (m_axi_rvalid && m_axi_rlast) begin
                        state_d    = ST_ADDR;
                        fetch_pc_d = redirect_pc;
                    end else begin
                        state_d   = ST_DRAIN;
                        pend_pc_d = redirect_pc;
                        halt_d    = 1'b0;
                    end
                end else if (m_axi_rvalid) begin
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                        if (m_axi_rlast) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_DRAIN;
                            halt_d  = 1'b1;
                        end
                    end else if (m_axi_rlast) begin
                        state_d    = ST_ADDR;
                        fetch_pc_d = araddr_q + ADDR_WIDTH'(LINE_B);
                    end
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pend_pc_d = redirect_pc;
                    halt_d    = 1'b0;
                end
                if (m_axi_rvalid && m_axi_rlast) begin
                    if (redirect_valid) begin
                        state_d    = ST_ADDR;
                        fetch_pc_d = redirect_pc;
                    end else if (halt_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d    = ST_ADDR;
                        fetch_pc_d = pend_pc;
                    end
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d    = ST_ADDR;
                    fetch_pc_d = redirect_pc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ADDR;
            fetch_pc  <= entry;
            pend_pc   <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            redir_q   <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
            beat_q    <= '0;
        end else begin
            state     <= state_d;
            fetch_pc  <= fetch_pc_d;
            pend_pc   <= pend_pc_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            redir_q   <= redir_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
        end
    end

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW),
        .LANES (LANES)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push_en   (push_en),
        .push_data (push_data),
        .pop       (out_valid && out_ready),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = axi_size(DATA_WIDTH);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state == ST_DATA) || (state == ST_DRAIN);
    assign out_valid     = !fifo_empty;
    assign out_inst      = head[31:0];
    assign out_pc        = head[EW-1:32];
    assign fetch_err     = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: AXI slave model plus an
// instruction-stream reference (sequential PCs, redirects restart).
module tb_fetch_unit;

    localparam int IDW   = 13;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BL    = 8;
    localparam int DEPTH = 32;

    logic          clk;
    logic          reset;
    logic [AW-1:0] entry;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_pc;
    logic          fetch_err;

    fetch_unit #(
        .ID_WIDTH   (IDW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .m_axi_arid     (m_axi_arid),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [63:0] exp_pc;
    int          n_pop;
    int          n_beats;
    int          beat;
    int          err_beat;
    int          pop_limit;
    bit          rand_mode;
    bit          do_redir;
    logic [63:0] redir_to;
    logic [63:0] pop_q[$];
    logic [63:0] ar_q[$];
    logic [63:0] rq[$];
    logic        last_ov;
    logic        last_arv;
    logic        last_err;

    // Program memory contents: a fixed hash of the word address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] x;
        x = a[31:0] ^ a[63:32];
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [63:0] ba;
        @(negedge clk);
        m_axi_arready = rand_mode ? ($urandom % 3 != 0) : 1'b1;
        out_ready = (n_pop < pop_limit) &&
                    (!rand_mode || ($urandom % 4 != 0));
        redirect_valid = do_redir;
        redirect_pc = redir_to;
        do_redir = 1'b0;
        if (rq.size() > 0) begin
            ba = rq[0] + 64'(beat * 8);
            m_axi_rvalid = rand_mode ? ($urandom % 4 != 0) : 1'b1;
            m_axi_rdata  = {mem_word(ba + 64'd4), mem_word(ba)};
            m_axi_rlast  = (beat == BL - 1);
            m_axi_rresp  = (beat == err_beat) ? 2'd2 : 2'd0;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'd0;
        end
        #1;
        last_ov  = out_valid;
        last_arv = m_axi_arvalid;
        last_err = fetch_err;
        chk("fifo_room", 64'(int'(dut.fifo_count) +
            $countones(dut.push_en) <= DEPTH), 64'd1);
        if (m_axi_arvalid && m_axi_arready) begin
            chk("arlen", 64'(m_axi_arlen), 64'd7);
            chk("arsize", 64'(m_axi_arsize), 64'd3);
            chk("arburst", 64'(m_axi_arburst), 64'd1);
            chk("arid", 64'(m_axi_arid), 64'd0);
            ar_q.push_back(m_axi_araddr);
            rq.push_back(m_axi_araddr);
        end
        if (m_axi_rvalid && m_axi_rready) begin
            if (beat == err_beat) err_beat = -1;
            n_beats++;
            if (m_axi_rlast) begin
                void'(rq.pop_front());
                beat = 0;
            end else begin
                beat++;
            end
        end
        if (out_valid && out_ready && !redirect_valid) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_inst", 64'(out_inst), 64'(mem_word(exp_pc)));
            pop_q.push_back(out_pc);
            n_pop++;
            exp_pc = exp_pc + 64'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        @(posedge clk);
    endtask

    task automatic finish_reset();
        rq.delete();
        ar_q.delete();
        pop_q.delete();
        beat = 0;
        n_beats = 0;
        n_pop = 0;
        err_beat = -1;
        exp_pc = entry;
        redirect_valid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fetch_err", 64'(fetch_err), 64'd0);
        chk("rst_araddr", m_axi_araddr, 64'd0);
        reset = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] e);
        entry = e;
        reset = 1'b1;
        finish_reset();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic until_pops(input int n, input int maxc);
        for (int i = 0; i < maxc && n_pop < n; i++) step();
        chk("wait_pops", 64'(n_pop >= n), 64'd1);
    endtask

    task automatic until_ars(input int n, input int maxc);
        for (int i = 0; i < maxc && ar_q.size() < n; i++) step();
        chk("wait_ars", 64'(ar_q.size() >= n), 64'd1);
    endtask

    task automatic until_beats(input int n, input int maxc);
        for (int i = 0; i < maxc && n_beats < n; i++) step();
        chk("wait_beats", 64'(n_beats >= n), 64'd1);
    endtask

    initial begin
        int k;
        rand_mode = 1'b0;
        do_redir = 1'b0;
        redir_to = '0;
        redirect_pc = '0;
        m_axi_rdata = '0;
        pop_limit = 1 << 30;

        // Aligned entry: one line, then the next line.
        do_reset(64'h1000);
        until_beats(1, 40);
        step();
        chk("latency_out_valid", 64'(last_ov), 64'd1);
        until_pops(16, 200);
        until_ars(2, 200);
        chk("ar0", ar_q[0], 64'h1000);
        chk("ar1", ar_q[1], 64'h1040);
        chk("pop_first", pop_q[0], 64'h1000);
        chk("pop_16th", pop_q[15], 64'h103C);

        // Unaligned entry drops the leading slots.
        do_reset(64'h1008);
        until_pops(15, 200);
        chk("ua_ar0", ar_q[0], 64'h1000);
        chk("ua_first", pop_q[0], 64'h1008);
        chk("ua_14th", pop_q[13], 64'h103C);
        chk("ua_15th", pop_q[14], 64'h1040);

        // Credit gating with a stalled consumer.
        do_reset(64'h1000);
        pop_limit = 0;
        run(80);
        chk("cr_ars", 64'(ar_q.size()), 64'd2);
        chk("cr_arvalid", 64'(last_arv), 64'd0);
        chk("cr_full", 64'(last_ov), 64'd1);
        pop_limit = 1;
        run(30);
        chk("cr_one_pop", 64'(n_pop), 64'd1);
        chk("cr_ars_1pop", 64'(ar_q.size()), 64'd2);
        pop_limit = 15;
        run(40);
        chk("cr_ars_15pop", 64'(ar_q.size()), 64'd2);
        pop_limit = 16;
        until_ars(3, 60);
        chk("cr_ar2", ar_q[2], 64'h1080);
        pop_limit = 1 << 30;

        // Redirect mid-burst.
        do_reset(64'h1000);
        until_beats(3, 40);
        do_redir = 1'b1;
        redir_to = 64'h2000;
        k = n_pop;
        step();
        step();
        chk("rd_flush", 64'(last_ov), 64'd0);
        until_ars(2, 100);
        chk("rd_beats", 64'(n_beats), 64'd8);
        chk("rd_ar1", ar_q[1], 64'h2000);
        until_pops(k + 1, 100);
        chk("rd_first", pop_q[k], 64'h2000);

        // Error response halts fetch until redirected.
        do_reset(64'h1000);
        err_beat = 1;
        run(60);
        chk("er_flag", 64'(last_err), 64'd1);
        chk("er_ars", 64'(ar_q.size()), 64'd1);
        chk("er_pops", 64'(n_pop), 64'd2);
        do_redir = 1'b1;
        redir_to = 64'h3000;
        step();
        step();
        chk("er_clear", 64'(last_err), 64'd0);
        until_ars(2, 60);
        chk("er_ar1", ar_q[1], 64'h3000);
        until_pops(3, 100);
        chk("er_first", pop_q[2], 64'h3000);

        // Asynchronous reset in the middle of a burst.
        do_reset(64'h1000);
        until_beats(2, 40);
        #3;
        chk("ar_mid_rready", 64'(m_axi_rready), 64'd1);
        entry = 64'h5000;
        reset = 1'b1;
        #1;
        chk("ar_async_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("ar_async_rready", 64'(m_axi_rready), 64'd0);
        chk("ar_async_out_valid", 64'(out_valid), 64'd0);
        finish_reset();
        until_ars(1, 40);
        chk("ar_new_entry", ar_q[0], 64'h5000);
        until_pops(4, 100);
        chk("ar_new_first", pop_q[0], 64'h5000);

        // Randomised handshakes and redirects against the stream model.
        rand_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_reset(64'h10000 + (64'($urandom_range(0, 255)) << 2));
            for (int c = 0; c < 400; c++) begin
                if ($urandom % 60 == 0) begin
                    do_redir = 1'b1;
                    redir_to = 64'h20000 +
                        (64'($urandom_range(0, 1023)) << 2);
                end
                step();
            end
            chk("rand_progress", 64'(n_pop > 0), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
